// File: rtl/tdm_demux_pkg.sv
// Shared TDM definitions: link alignment states and slot-index helpers.
package tdm_demux_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } tdm_state_e;

  // LSB position of slot k inside a flattened multi-slot word.
  function automatic int unsigned slot_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-NCH slot counter with enable, synchronous load-to-1, clear and terminal count.
module tdm_slot_counter #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load1,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(NCH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CW'(1);
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: aligns on SOF, collects NCH slots and publishes whole frames.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           valid_in,
  input  logic           sof,
  output logic [NCH*W-1:0] dout,
  output logic           frame_valid,
  output logic           locked,
  output logic           sync_err
);

  localparam int CW = $clog2(NCH);

  tdm_state_e state, next_state;

  logic [CW-1:0]         cnt;
  logic                  tc;
  logic                  cnt_en, cnt_load1, cnt_clr;
  logic                  wr_en;
  logic [CW-1:0]         wr_idx;
  logic                  publish;
  logic                  err;
  logic [(NCH-1)*W-1:0]  shadow;

  tdm_slot_counter #(
    .NCH (NCH),
    .CW  (CW)
  ) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .load1 (cnt_load1),
    .clr   (cnt_clr),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HUNT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cnt_en     = 1'b0;
    cnt_load1  = 1'b0;
    cnt_clr    = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = cnt;
    publish    = 1'b0;
    err        = 1'b0;
    if (valid_in) begin
      case (state)
        ST_HUNT: begin
          if (sof) begin
            wr_en      = 1'b1;
            wr_idx     = '0;
            cnt_load1  = 1'b1;
            next_state = ST_LOCK;
          end
        end
        ST_LOCK: begin
          // In-order beat: SOF present exactly when the counter is at slot 0.
          if ((cnt == '0) == sof) begin
            wr_en   = !tc;
            publish = tc;
            cnt_en  = 1'b1;
          end else if (sof) begin
            err       = 1'b1;
            wr_en     = 1'b1;
            wr_idx    = '0;
            cnt_load1 = 1'b1;
          end else begin
            err        = 1'b1;
            cnt_clr    = 1'b1;
            next_state = ST_HUNT;
          end
        end
        default: next_state = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= publish;
      sync_err    <= err;
      for (int unsigned k = 0; k < NCH - 1; k++) begin
        if (wr_en && wr_idx == CW'(k)) begin
          shadow[slot_lsb(k, W) +: W] <= din;
        end
      end
      // Last slot bypasses the shadow so the frame lands on the edge that samples it.
      if (publish) begin
        dout <= {din, shadow};
      end
    end
  end

  assign locked = (state == ST_LOCK);

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized and directed scoreboard bench for tdm_demux against a slot-queue reference model.
module tb_tdm_demux;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     din = '0;
  logic             valid_in = 1'b0;
  logic             sof = 1'b0;
  logic [NCH*W-1:0] dout;
  logic             frame_valid;
  logic             locked;
  logic             sync_err;

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .valid_in    (valid_in),
    .sof         (sof),
    .dout        (dout),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               is_err;
    logic [NCH*W-1:0] frame;
  } ev_t;

  ev_t              sb[$];
  int               tests = 0;
  int               fails = 0;

  // Reference model: alignment flag plus the list of slots collected so far.
  bit               m_locked = 0;
  logic [W-1:0]     m_slots[$];
  logic [NCH*W-1:0] exp_dout = '0;
  bit               exp_fv = 0;
  bit               exp_err = 0;
  bit               mon_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input bit v, input bit s, input logic [W-1:0] d);
    ev_t e;
    int  n;
    exp_fv  = 0;
    exp_err = 0;
    if (!v) return;
    n = m_slots.size();
    if (!m_locked) begin
      if (s) begin
        m_slots.delete();
        m_slots.push_back(d);
        m_locked = 1;
      end
    end else if ((s && n == 0) || (!s && n > 0)) begin
      m_slots.push_back(d);
      if (m_slots.size() == NCH) begin
        for (int i = 0; i < NCH; i++) exp_dout[i*W +: W] = m_slots[i];
        m_slots.delete();
        exp_fv   = 1;
        e.is_err = 0;
        e.frame  = exp_dout;
        sb.push_back(e);
      end
    end else begin
      exp_err  = 1;
      e.is_err = 1;
      e.frame  = '0;
      sb.push_back(e);
      m_slots.delete();
      if (s) m_slots.push_back(d);
      else   m_locked = 0;
    end
  endtask

  task automatic beat(input bit v, input bit s, input logic [W-1:0] d);
    valid_in = v;
    sof      = s;
    din      = d;
    @(posedge clk);
    model_step(v, s, d);
    #1;
    valid_in = 1'b0;
    sof      = 1'b0;
  endtask

  task automatic send_frame(input logic [NCH*W-1:0] f, input int gap);
    for (int i = 0; i < NCH; i++) begin
      beat(1'b1, i == 0, f[i*W +: W]);
      for (int g = 0; g < gap; g++) beat(1'b0, 1'b0, 8'hEE);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_dout", 64'(dout), 64'h0);
    check("rst_fv", 64'(frame_valid), 64'h0);
    check("rst_locked", 64'(locked), 64'h0);
    check("rst_err", 64'(sync_err), 64'h0);
    m_locked = 0;
    m_slots.delete();
    exp_dout = '0;
    exp_fv   = 0;
    exp_err  = 0;
    check("rst_sb_empty", 64'(sb.size()), 64'h0);
    sb.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: cycle-accurate strobe/level checks plus scoreboard pops on DUT events.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      ev_t e;
      check("fv", 64'(frame_valid), 64'(exp_fv));
      check("sync_err", 64'(sync_err), 64'(exp_err));
      check("locked", 64'(locked), 64'(m_locked));
      check("dout_hold", 64'(dout), 64'(exp_dout));
      if (frame_valid && sync_err) check("fv_err_excl", 64'h1, 64'h0);
      if (frame_valid || sync_err) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", 64'({frame_valid, sync_err}), 64'h0);
        end else begin
          e = sb.pop_front();
          check("sb_kind", 64'(sync_err), 64'(e.is_err));
          if (!e.is_err) check("sb_frame", 64'(dout), 64'(e.frame));
        end
      end
    end
  end

  initial begin
    logic [NCH*W-1:0] f;
    int p;
    bit v, s;
    #3;
    do_reset();
    mon_en = 1;

    // Basic frame, then the same with idle gaps.
    send_frame(32'h44332211, 0);
    beat(1'b0, 1'b0, 8'h00);
    send_frame(32'h44332211, 1);

    // Early SOF drops the partial frame.
    beat(1'b1, 1'b1, 8'hAA);
    beat(1'b1, 1'b0, 8'hBB);
    send_frame(32'h04030201, 0);

    // Missing SOF unlocks; stray beats ignored until the next SOF.
    beat(1'b1, 1'b0, 8'h55);
    beat(1'b1, 1'b0, 8'h66);
    beat(1'b1, 1'b0, 8'h77);
    send_frame(32'hDDCCBBAA, 0);

    // Reset mid-frame.
    beat(1'b1, 1'b1, 8'h10);
    beat(1'b1, 1'b0, 8'h20);
    do_reset();
    send_frame(32'h89ABCDEF, 0);

    // Eight back-to-back frames.
    for (int k = 0; k < 8; k++) begin
      f = {$urandom, $urandom};
      send_frame(f, 0);
    end

    // Random traffic with gaps and occasional alignment faults.
    p = 0;
    for (int k = 0; k < 600; k++) begin
      v = ($urandom_range(0, 3) != 0);
      s = (p == 0);
      if ($urandom_range(0, 11) == 0) s = ~s;
      beat(v, s, W'($urandom));
      if (v) p = (s ? 1 : p + 1) % NCH;
    end

    beat(1'b0, 1'b0, 8'h00);
    beat(1'b0, 1'b0, 8'h00);
    check("sb_drained", 64'(sb.size()), 64'h0);
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
